mem_req_arbiter: RTL and testbench

//   Shares one SRAM-like memory port between the instruction-fetch requester (IF stage)
//   and the data requester (EXE stage).
//   - Arbitrates requests, holds the grant until the address handshake completes, and

---
 rtl/mem_req_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: one SRAM-like port shared by inst (IF) and data (EXE) requesters, with in-order return routing.
// Latency: zero cycles from *_req to mem_req and from mem_addr_ok to *_addr_ok; mem_data_ok is routed in the same cycle.
// Backpressure: *_addr_ok is withheld when the requester loses, is locked out, or OUTSTANDING are unreturned. ARB_ROUND_ROBIN_EN selects round-robin.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t              state_q, state_d;
    logic                    lock_id_q, lock_id_d;
    logic [OUTSTANDING-1:0]  id_q, id_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic                    rr_q, rr_d;
`endif

    logic grant;
    logic grant_req;
    logic full;
    logic empty;
    logic handshake;
    logic pop;
    logic head_id;

    // full/empty depend only on registered count, so mem_data_ok never reaches mem_req
    assign full  = (count_q == CNT_W'(OUTSTANDING));
    assign empty = (count_q == '0);

    always_comb begin
        grant = ID_DATA;
        if (state_q == ARB_LOCKED) begin
            grant = lock_id_q;
        end else if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant = rr_q;
`else
            grant = ID_DATA;
`endif
        end else if (inst_req) begin
            grant = ID_INST;
        end
    end

    assign grant_req = (grant == ID_DATA) ? data_req : inst_req;
    assign mem_req   = ~reset & grant_req & ~full;
    assign handshake = mem_req & mem_addr_ok;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            if (grant == ID_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wstrb = inst_wstrb;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = handshake & (grant == ID_INST);
    assign data_addr_ok = handshake & (grant == ID_DATA);

    // a response with nothing outstanding (e.g. after reset) is dropped silently
    assign pop     = ~reset & mem_data_ok & ~empty;
    assign head_id = id_q[rd_ptr_q];

    assign inst_data_ok = pop & (head_id == ID_INST);
    assign data_data_ok = pop & (head_id == ID_DATA);
    assign inst_rdata   = reset ? 32'h0 : mem_rdata;
    assign data_rdata   = reset ? 32'h0 : mem_rdata;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB_OPEN: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = grant;
                end
            end
            ARB_LOCKED: begin
                if (handshake) begin
                    state_d = ARB_OPEN;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (handshake) begin
            id_d[wr_ptr_q] = grant;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({handshake, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            rr_d = ~grant;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_OPEN;
            lock_id_q <= ID_INST;
            id_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q      <= ID_DATA;
`endif
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            id_q      <= id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_req_arbiter;

    localparam int OUT = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int stray_cnt = 0;

    mem_req_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // responses offered with nothing outstanding
    always @(negedge clk) begin
        if (!reset && mem_data_ok && !inst_data_ok && !data_data_ok) stray_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic r, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        inst_req = r; inst_wr = w; inst_size = sz; inst_addr = a; inst_wstrb = st; inst_wdata = wd;
    endtask

    task automatic set_data(input logic r, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        data_req = r; data_wr = w; data_size = sz; data_addr = a; data_wstrb = st; data_wdata = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_inst(0, 0, 0, 0, 0, 0);
        set_data(0, 0, 0, 0, 0, 0);
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inst(1, 0, 2, 32'h1c00_0000, 0, 0);
        set_data(1, 1, 2, 32'h0000_1000, 4'hf, 32'h1234_5678);
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hdead_beef;
        tick(); tick();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
            begin n_fail++; $display("FAIL rst_oks got %b exp 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0)
            begin n_fail++; $display("FAIL rst_rdata got %h/%h exp 0", inst_rdata, data_rdata); end
        tick();
        do_reset();
        mem_data_ok = 1;
        @(negedge clk);
        n_checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL rst_empty_dok got %b%b exp 00", inst_data_ok, data_data_ok); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_priority();
        do_reset();
        set_data(1, 0, 2, 32'h0000_1000, 0, 0);
        set_inst(1, 0, 2, 32'h1c00_0000, 0, 0);
        mem_addr_ok = 1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL pri_mem_req got %0b exp 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL pri_addr1 got %h exp 00001000", mem_addr); end
        n_checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0)
            begin n_fail++; $display("FAIL pri_aok1 got d%0b i%0b exp d1 i0", data_addr_ok, inst_addr_ok); end
        tick();
        data_req = 0;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h1c00_0000) begin n_fail++; $display("FAIL pri_addr2 got %h exp 1c000000", mem_addr); end
        n_checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0)
            begin n_fail++; $display("FAIL pri_aok2 got i%0b d%0b exp i1 d0", inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0)
            begin n_fail++; $display("FAIL pri_idle got req%0b addr %h exp req0 addr 0", mem_req, mem_addr); end
        n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL pri_dok1 got d%0b i%0b exp d1 i0", data_data_ok, inst_data_ok); end
        n_checks++; if (data_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL pri_rdata1 got %h exp 11112222", data_rdata); end
        tick();
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL pri_dok2 got i%0b d%0b exp i1 d0", inst_data_ok, data_data_ok); end
        n_checks++; if (inst_rdata !== 32'h3333_4444) begin n_fail++; $display("FAIL pri_rdata2 got %h exp 33334444", inst_rdata); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_lock();
        do_reset();
        set_inst(1, 0, 2, 32'h1c00_0000, 0, 0);
        mem_addr_ok = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_data(1, 0, 2, 32'h0000_2000, 0, 0);
            @(negedge clk);
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1c00_0000)
                begin n_fail++; $display("FAIL lock_hold%0d got req%0b addr %h exp req1 addr 1c000000", c, mem_req, mem_addr); end
            n_checks++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0)
                begin n_fail++; $display("FAIL lock_aok%0d got i%0b d%0b exp 0 0", c, inst_addr_ok, data_addr_ok); end
            tick();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        n_checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'h1c00_0000)
            begin n_fail++; $display("FAIL lock_accept got i%0b d%0b addr %h exp i1 d0 1c000000", inst_addr_ok, data_addr_ok, mem_addr); end
        tick();
        inst_req = 0;
        @(negedge clk);
        n_checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h0000_2000)
            begin n_fail++; $display("FAIL lock_next got d%0b addr %h exp d1 00002000", data_addr_ok, mem_addr); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL lock_dok1 got i%0b d%0b exp i1 d0", inst_data_ok, data_data_ok); end
        tick();
        @(negedge clk);
        n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL lock_dok2 got d%0b i%0b exp d1 i0", data_data_ok, inst_data_ok); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_full();
        do_reset();
        set_data(1, 0, 2, 32'h0000_3000, 0, 0);
        mem_addr_ok = 1;
        for (int c = 0; c < OUT; c++) begin
            @(negedge clk);
            n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got %0b exp 1", c, data_addr_ok); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || data_addr_ok !== 1'b0 || mem_addr !== 32'h0)
            begin n_fail++; $display("FAIL full_block got req%0b aok%0b addr %h exp 0 0 0", mem_req, data_addr_ok, mem_addr); end
        tick();
        mem_data_ok = 1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_req got %0b exp 0", mem_req); end
        n_checks++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_pop_dok got %0b exp 1", data_data_ok); end
        tick();
        mem_data_ok = 0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || data_addr_ok !== 1'b1)
            begin n_fail++; $display("FAIL full_resume got req%0b aok%0b exp 1 1", mem_req, data_addr_ok); end
        tick();
        data_req = 0; mem_data_ok = 1;
        for (int c = 0; c < OUT + 1; c++) begin
            @(negedge clk);
            n_checks++; if (data_data_ok !== (c < OUT))
                begin n_fail++; $display("FAIL full_drain%0d got %0b exp %0b", c, data_data_ok, (c < OUT)); end
            tick();
        end
        mem_data_ok = 0;
    endtask

    task automatic test_write();
        do_reset();
        set_data(1, 1, 2, 32'h0000_4000, 4'b0011, 32'h0000_beef);
        mem_addr_ok = 1;
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h0000_beef || mem_size !== 2'b10)
            begin n_fail++; $display("FAIL wr_fields got wr%0b st%b wd%h sz%b exp 1 0011 0000beef 10", mem_wr, mem_wstrb, mem_wdata, mem_size); end
        n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_aok got %0b exp 1", data_addr_ok); end
        tick();
        set_data(0, 0, 0, 0, 0, 0);
        set_inst(1, 0, 1, 32'h1c00_0010, 4'hf, 32'hffff_ffff);
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b0 || mem_size !== 2'b01 || inst_addr_ok !== 1'b1)
            begin n_fail++; $display("FAIL wr_rd_fields got wr%0b sz%b aok%0b exp 0 01 1", mem_wr, mem_size, inst_addr_ok); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL wr_dok got d%0b i%0b exp d1 i0", data_data_ok, inst_data_ok); end
        tick();
        @(negedge clk);
        n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0)
            begin n_fail++; $display("FAIL wr_rd_dok got i%0b d%0b exp i1 d0", inst_data_ok, data_data_ok); end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        set_data(1, 0, 2, 32'h0000_5000, 0, 0);
        set_inst(1, 0, 2, 32'h1c00_0020, 0, 0);
        mem_addr_ok = 1;
        tick();
        data_req = 0;
        tick();
        inst_req = 0; mem_addr_ok = 0;
        reset = 1;
        tick();
        reset = 0;
        base = stray_cnt;
        mem_data_ok = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0)
                begin n_fail++; $display("FAIL rmid_dok%0d got i%0b d%0b exp 0 0", c, inst_data_ok, data_data_ok); end
            tick();
        end
        mem_data_ok = 0;
        @(negedge clk);
        n_checks++; if (stray_cnt - base !== 2) begin n_fail++; $display("FAIL rmid_stray got %0d exp 2", stray_cnt - base); end
        tick();
        set_data(1, 0, 2, 32'h0000_6000, 0, 0);
        mem_addr_ok = 1;
        for (int c = 0; c < OUT; c++) begin
            @(negedge clk);
            n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_cnt%0d got %0b exp 1", c, data_addr_ok); end
            tick();
        end
        data_req = 0; mem_addr_ok = 0;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        do_reset();
        set_data(1, 0, 2, 32'h0000_7000, 0, 0);
        set_inst(1, 0, 2, 32'h1c00_0030, 0, 0);
        mem_addr_ok = 1;
        for (int i = 0; i < 6; i++) begin
            mem_data_ok = (i > 0);
            @(negedge clk);
            n_checks++; if (data_addr_ok !== (i % 2 == 0) || inst_addr_ok !== (i % 2 == 1))
                begin n_fail++; $display("FAIL rr_turn%0d got d%0b i%0b exp d%0b", i, data_addr_ok, inst_addr_ok, (i % 2 == 0)); end
            tick();
        end
        set_inst(0, 0, 0, 0, 0, 0);
        set_data(0, 0, 0, 0, 0, 0);
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask
`endif

    // reference model state: requesters indexed 0 = inst, 1 = data
    bit          pend[2];
    bit          f_wr[2];
    logic [1:0]  f_size[2];
    logic [31:0] f_addr[2];
    logic [3:0]  f_wstrb[2];
    logic [31:0] f_wdata[2];

    task automatic test_random();
        int  q[$];
        bit  lk_v;
        int  lk_id;
        int  pref;
        int  g;
        bit  exp_req, exp_acc, exp_pop;
        int  head;
        do_reset();
        lk_v = 0; lk_id = 0; pref = 1;
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r]    = 1;
                    f_wr[r]    = 1'($urandom_range(0, 1));
                    f_size[r]  = 2'($urandom_range(0, 2));
                    f_addr[r]  = $urandom;
                    f_wstrb[r] = 4'($urandom);
                    f_wdata[r] = $urandom;
                end
            end
            set_inst(pend[0], f_wr[0], f_size[0], f_addr[0], f_wstrb[0], f_wdata[0]);
            set_data(pend[1], f_wr[1], f_size[1], f_addr[1], f_wstrb[1], f_wdata[1]);
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;

            if (lk_v) g = lk_id;
            else if (pend[0] && pend[1]) g = RR ? pref : 1;
            else g = pend[1] ? 1 : 0;
            exp_req = pend[g] && (q.size() < OUT);
            exp_acc = exp_req && mem_addr_ok;
            exp_pop = mem_data_ok && (q.size() > 0);
            head    = (q.size() > 0) ? q[0] : 0;

            @(negedge clk);
            n_checks++; if (mem_req !== exp_req)
                begin n_fail++; $display("FAIL rnd_req c%0d got %0b exp %0b", cyc, mem_req, exp_req); end
            n_checks++; if (mem_addr !== (exp_req ? f_addr[g] : 32'h0) || mem_wr !== (exp_req ? f_wr[g] : 1'b0))
                begin n_fail++; $display("FAIL rnd_fields c%0d got %h/%0b exp %h/%0b", cyc, mem_addr, mem_wr,
                                         exp_req ? f_addr[g] : 32'h0, exp_req ? f_wr[g] : 1'b0); end
            n_checks++; if (inst_addr_ok !== (exp_acc && g == 0) || data_addr_ok !== (exp_acc && g == 1))
                begin n_fail++; $display("FAIL rnd_aok c%0d got i%0b d%0b exp i%0b d%0b", cyc, inst_addr_ok, data_addr_ok,
                                         exp_acc && g == 0, exp_acc && g == 1); end
            n_checks++; if (inst_data_ok !== (exp_pop && head == 0) || data_data_ok !== (exp_pop && head == 1))
                begin n_fail++; $display("FAIL rnd_dok c%0d got i%0b d%0b exp i%0b d%0b", cyc, inst_data_ok, data_data_ok,
                                         exp_pop && head == 0, exp_pop && head == 1); end
            n_checks++; if (data_rdata !== mem_rdata || inst_rdata !== mem_rdata)
                begin n_fail++; $display("FAIL rnd_rdata c%0d got %h/%h exp %h", cyc, inst_rdata, data_rdata, mem_rdata); end

            if (exp_pop) void'(q.pop_front());
            if (exp_acc) begin
                q.push_back(g);
                pend[g] = 0;
                lk_v    = 0;
                pref    = 1 - g;
            end else if (exp_req) begin
                lk_v  = 1;
                lk_id = g;
            end
            tick();
        end
        set_inst(0, 0, 0, 0, 0, 0);
        set_data(0, 0, 0, 0, 0, 0);
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_write();
        test_reset_mid();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
